// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_rosc_ctrl.sv
// Ring-oscillator measurement controller: gates an inverter ring on, lets it settle, then
// counts synchronized OSC rising edges over a programmable window and reports the result.
module gf180mcu_fd_sc_mcu7t5v0__inv_rosc_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             osc_i,
  output logic             en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TmrW = (WIN_W > SetW) ? WIN_W : SetW;
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StReport} state_e;

  state_e             state_q, state_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wovf_q, wovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // OSC is asynchronous: two-flop synchronizer followed by a registered rise detector
  logic sync1_q, sync2_q, prev_q, edge_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= osc_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    wovf_d  = wovf_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (state_q == StMeasure && edge_q) begin
      if (cnt_q == CntMax) begin
        wovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StSettle;
          win_d   = window_i;
          tmr_d   = SettleLast;
          cnt_d   = '0;
          wovf_d  = 1'b0;
        end
      end
      StSettle: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (tmr_q == '0) begin
          // A zero window skips MEASURE entirely
          if (win_q == '0) begin
            state_d = StReport;
          end else begin
            state_d = StMeasure;
            tmr_d   = TmrW'(win_q) - TmrW'(1);
          end
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StMeasure: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (tmr_q == '0) begin
          state_d = StReport;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StReport: begin
        state_d = StIdle;
      end
    endcase

    // Result is loaded on entry to REPORT so it includes the final MEASURE edge
    if (state_d == StReport) begin
      count_d = cnt_d;
      ovf_d   = wovf_d;
    end

    en_d   = (state_d == StSettle) || (state_d == StMeasure);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StReport);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      wovf_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      wovf_q  <= wovf_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en_o    = en_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__inv_rosc_ctrl.md
GF180MCU_FD_SC_MCU7T5V0__INV_ROSC_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__inv_rosc_ctrl

Interface
REQ-001 The block SHALL take parameter CNT_W, default 16, as the width of the edge counter and COUNT.
REQ-002 The block SHALL take parameter WIN_W, default 16, as the width of the measurement window.
REQ-003 The block SHALL take parameter SETTLE_CYC, default 8 (min 1), as the ring settle time in CLK cycles.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-high.
REQ-006 START  input  1  start-measurement request, level sampled each cycle.
REQ-007 ABORT  input  1  cancel the measurement in progress.
REQ-008 WINDOW  input  WIN_W  gate window length in CLK cycles, captured on START acceptance.
REQ-009 OSC  input  1  asynchronous output of the inverter ring under test.
REQ-010 EN  output  1  ring enable (drives the ring's gating NAND); high = oscillate.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 DONE  output  1  one-cycle pulse when COUNT becomes valid.
REQ-013 COUNT  output  CNT_W  OSC rising edges counted in the last completed window.
REQ-014 OVF  output  1  the counter saturated during the last completed window.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, MEASURE and REPORT.
REQ-016 In IDLE with START=1 and ABORT=0, the block SHALL capture WINDOW, clear the working counter and working overflow flag, and enter SETTLE on the next edge.
REQ-017 START SHALL be ignored in every state other than IDLE.
REQ-018 EN SHALL be registered, high exactly in SETTLE and MEASURE, and low in IDLE and REPORT.
REQ-019 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to MEASURE.
REQ-020 OSC SHALL pass through a 2-flop synchronizer and then a registered rising-edge detector; the detected-edge pulse SHALL be counted only in cycles where the state is MEASURE.
REQ-021 MEASURE SHALL last exactly the captured WINDOW cycles, then go to REPORT.
REQ-022 A captured WINDOW of 0 SHALL make MEASURE last 0 cycles: the FSM goes SETTLE -> REPORT and the count is 0.
REQ-023 The working counter SHALL saturate at 2^CNT_W-1; an edge detected while the counter is saturated SHALL set the working overflow flag.
REQ-024 REPORT SHALL last 1 cycle, during which COUNT and OVF are loaded from the working registers and DONE=1; the FSM then returns to IDLE.
REQ-025 COUNT and OVF SHALL hold their values until the next REPORT or reset.
REQ-026 Latency SHALL be as follows, with START accepted at edge 0: EN rises after edge 1, DONE is high in cycle 1+SETTLE_CYC+WINDOW.
REQ-027 ABORT=1 in SETTLE, MEASURE or REPORT SHALL return the FSM to IDLE on the next edge with EN=0 and no DONE.
REQ-028 On ABORT, COUNT and OVF SHALL be left unchanged.
REQ-029 ABORT SHALL take priority over START when both are high in IDLE, and the request SHALL not be accepted.
REQ-030 A valid count requires the OSC frequency to be below CLK/2; faster OSC signals are undercounted, and no detection of this condition is required.

Reset
REQ-031 While RST is high, the block SHALL be in IDLE with EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0, the synchronizer flops at 0, the edge detector at 0 and the working counter at 0.
REQ-032 RST asserted mid-measurement SHALL immediately (asynchronously) force EN low and no DONE pulse SHALL follow.
REQ-033 Reset release SHALL be synchronous to CLK; the first START SHALL be accepted on the first edge after release.

Verification
REQ-034 SETTLE_CYC=8, WINDOW=100, OSC is a square wave of period 4 CLK: the bench SHALL check EN high for 108 cycles, DONE in cycle 109, COUNT=25±1 and OVF=0.
REQ-035 CNT_W=4, WINDOW=100, OSC period 4: the bench SHALL check COUNT=15 and OVF=1.
REQ-036 WINDOW=0: the bench SHALL check DONE in cycle 9, COUNT=0, OVF=0 and EN high for exactly 8 cycles.
REQ-037 A completed run with COUNT=25, followed by a new run with ABORT pulsed in MEASURE: the bench SHALL check EN=0 the next cycle, no DONE, COUNT still 25 and BUSY=0.
REQ-038 START held high continuously over two windows: the bench SHALL check that the back-to-back runs are separated by exactly 1 IDLE cycle after REPORT, and that START pulses during BUSY are ignored.
REQ-039 RST asserted mid-MEASURE between clock edges: the bench SHALL check EN, BUSY, COUNT and OVF all 0 immediately, with no DONE.
